// File: rtl/video_pkg.sv
// video_pkg: capture-state encodings and the RBG<->RGB channel swap shared by the
// video-in and video-out bridges.
`default_nettype none

package video_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'b00,
    CAPTURE  = 2'b01,
    DROP     = 2'b10
  } cap_state_t;

  // Source pixels arrive as {R,B,G}; the stream carries {R,G,B}.
  function automatic logic [23:0] rbg_to_rgb(input logic [23:0] rbg);
    return {rbg[23:16], rbg[7:0], rbg[15:8]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock first-word-fall-through FIFO with occupancy counter.
// Rev 1.0
`default_nettype none

module axis_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      count;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a push at full is still accepted.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Gating on empty keeps the output at zero in reset without resetting the array.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/video_to_axis.sv
// video_to_axis: VTC-timed parallel RGB capture into an AXI-Stream with tuser/tlast
// markers; overruns drop the rest of the frame and resync on the next vsync.
`default_nettype none

module video_to_axis
  import video_pkg::*;
#(
  parameter int STREAM_WIDTH     = 24,
  parameter int VIDEO_DATA_WIDTH = 24,
  parameter int FIFO_DEPTH       = 32
) (
  input  logic                        video_clk,
  input  logic                        reset,
  input  logic [VIDEO_DATA_WIDTH-1:0] vid_data,
  input  logic                        vid_active_video,
  input  logic                        vid_hsync,
  input  logic                        vid_vsync,
  output logic [STREAM_WIDTH-1:0]     m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        locked,
  output logic                        overflow,
  input  logic                        overflow_clr
);

  localparam int FW = STREAM_WIDTH + 2;

  logic [VIDEO_DATA_WIDTH-1:0] data_d1;
  logic                        active_d1;
  logic                        vsync_d1;
  logic                        hsync_d1;
  logic                        unused_hsync;

  cap_state_t state;
  cap_state_t state_next;

  logic          sof_pending;
  logic          vsync_rise;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          write;
  logic          overrun;
  logic [FW-1:0] wr_word;
  logic [FW-1:0] rd_word;

  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      data_d1   <= '0;
      active_d1 <= 1'b0;
      vsync_d1  <= 1'b0;
      hsync_d1  <= 1'b0;
    end else begin
      data_d1   <= vid_data;
      active_d1 <= vid_active_video;
      vsync_d1  <= vid_vsync;
      hsync_d1  <= vid_hsync;
    end
  end

  // Line boundaries come from active_video only.
  assign unused_hsync = hsync_d1;

  assign vsync_rise = vid_vsync & ~vsync_d1;
  assign pop        = m_axis_tvalid & m_axis_tready;

  // tlast looks ahead at the raw qualifier; a coincident vsync_rise leaves the pixel untagged.
  assign wr_word = {sof_pending & ~vsync_rise,
                    active_d1 & ~vid_active_video,
                    STREAM_WIDTH'(rbg_to_rgb(24'(data_d1)))};

  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) state <= WAIT_SOF;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    write      = 1'b0;
    overrun    = 1'b0;
    case (state)
      WAIT_SOF, DROP: begin
        if (vsync_rise) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (active_d1) begin
          if (fifo_full && !pop) begin
            overrun    = 1'b1;
            state_next = DROP;
          end else begin
            write = 1'b1;
          end
        end
      end
      default: state_next = WAIT_SOF;
    endcase
  end

  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      sof_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (vsync_rise)  sof_pending <= 1'b1;
      else if (write)  sof_pending <= 1'b0;
      if (overrun)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  axis_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (video_clk),
    .rst   (reset),
    .push  (write),
    .din   (wr_word),
    .pop   (pop),
    .dout  (rd_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tuser  = rd_word[FW-1];
  assign m_axis_tlast  = rd_word[FW-2];
  assign m_axis_tdata  = rd_word[STREAM_WIDTH-1:0];
  assign locked        = (state == CAPTURE);

endmodule

`default_nettype wire
